shift_lr_seq: RTL and testbench
===============================

Name: shift_lr_seq

Overview:
- Parametrised, sequenced successor to the team's 8-bit load/shift-left/right register.
- On a start strobe it loads a word, then shifts it one position per clock for a programmable number of steps.
- Supports logical, arithmetic, rotate and serial-fill modes, with busy/done handshake, abort and serial-out.
- Sits between datapath registers and serial links or bit-serial arithmetic units.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- AMT_W, 4, width of the step-count input; maximum steps = 2^AMT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- abort  input  1  terminate an operation in progress.
- mode  input  3  shift mode, sampled with start.
- amount  input  AMT_W  number of single-bit steps, sampled with start.
- in  input  WIDTH  parallel load word, sampled with start.
- ser_in  input  1  fill bit for serial modes, sampled every step.
- q  output  WIDTH  shift register contents.
- busy  output  1  high while steps remain.
- done  output  1  one-cycle completion pulse.
- ser_out  output  1  bit shifted out on the most recent step.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset values: q=0, busy=0, done=0, ser_out=0, state=IDLE, internal count=0, latched mode=0.
- States:
  - IDLE: q holds.
  - SHIFT: one step per clock.
- start in IDLE:
  - q<=in; latch mode; cnt<=amount; ser_out<=0.
  - amount!=0: state->SHIFT, busy<=1, done<=0.
  - amount==0: stay IDLE, done<=1 on that same edge (q=in).
- start while busy: ignored; latched operands unchanged.
- SHIFT, each clock:
  - Apply one step per the latched mode; cnt<=cnt-1.
  - On the step where cnt==1: state->IDLE, busy<=0, done<=1. done is high exactly in the cycle q first shows the final value.
- Latency: final result and done appear amount clocks after the start edge. busy is high for exactly amount cycles.
- done: deasserts on the next clock unless a new amount==0 start occurs.
- Mode encoding (one step). Left shifts emit ser_out=q[WIDTH-1]; right shifts emit ser_out=q[0].
  - 000 LSL: {q[W-2:0],0}.
  - 001 LSR: {0,q[W-1:1]}.
  - 010 ROL: {q[W-2:0],q[W-1]}.
  - 011 ROR: {q[0],q[W-1:1]}.
  - 100 ASR: {q[W-1],q[W-1:1]}.
  - 101 SIL: {q[W-2:0],ser_in}.
  - 110 SIR: {ser_in,q[W-1:1]}.
  - 111 HOLD: q unchanged; ser_out<=0; counting and done still run.
- amount > WIDTH is legal:
  - Logical shifts saturate to 0.
  - ASR saturates to all sign bits.
  - Rotates wrap modulo WIDTH.
- abort:
  - In SHIFT: state->IDLE, busy<=0, done stays 0. q keeps its value after the last completed step; no step is applied on the abort edge.
  - In IDLE: ignored.
  - abort and start in the same IDLE cycle: start wins.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset release, then start mode=000, in=8'hB5, amount=3 -> busy high for 3 cycles. q steps 6A, D4, A8; done pulses with q=8'hA8; ser_out sequence 1, 0, 1.
- mode=011 ROR, in=8'h81, amount=1 -> q=8'hC0 after 1 cycle. Repeat with amount=9 -> q=8'hC0 after 9 cycles, busy 9 cycles.
- mode=100 ASR, in=8'h90, amount=2 -> q=8'hE4. Then in=8'h90, amount=15 -> q=8'hFF. mode=001, in=8'hFF, amount=10 -> q=8'h00.
- mode=101 SIL, in=8'h00, ser_in=1, amount=4 -> q=8'h0F, ser_out=0 throughout. mode=110, ser_in toggling 1,0,1, in=8'h00, amount=3 -> q=8'hA0.
- amount=0 start with in=8'h5A -> q=8'h5A and done high one cycle after the edge, busy never high. A second start during a 5-step op -> ignored, result unchanged.
- abort after 2 of 5 LSL steps on in=8'h01 -> q=8'h04, busy low, no done. Separately, reset low mid-op -> q=0, busy=0, done=0 asynchronously.

Source files
------------

// File: rtl/shift_lr_seq.sv
// ---------------------------------------------------------------------------
// shift_lr_seq
//   Sequenced load/shift register. A start strobe in IDLE loads a word, then
//   the word is shifted one position per clock for 'amount' steps using the
//   latched mode (logical, arithmetic, rotate, serial fill or hold).
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    begin operation (sampled only in IDLE)
//   abort    terminate an operation in progress (ignored in IDLE)
//   mode     shift mode, latched with start
//   amount   number of single-bit steps, latched with start
//   in       parallel load word, latched with start
//   ser_in   fill bit for serial modes, sampled every step
//   q        shift register contents
//   busy     high while steps remain
//   done     one-cycle completion pulse, coincident with the final q
//   ser_out  bit shifted out on the most recent step
// ---------------------------------------------------------------------------
module shift_lr_seq #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] in,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             ser_out
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      M_LSL  = 3'b000,
      M_LSR  = 3'b001,
      M_ROL  = 3'b010,
      M_ROR  = 3'b011,
      M_ASR  = 3'b100,
      M_SIL  = 3'b101,
      M_SIR  = 3'b110,
      M_HOLD = 3'b111
   } mode_t;

   state_t           state, state_n;
   mode_t            mode_r, mode_n;
   logic [AMT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] q_n;
   logic             busy_n, done_n, ser_out_n;

   // Result of one step on the current q with the latched mode.
   logic [WIDTH-1:0] step_q;
   logic             step_so;

   always_comb begin
      step_q  = q;
      step_so = 1'b0;
      unique case (mode_r)
         M_LSL:  begin step_q = {q[WIDTH-2:0], 1'b0};       step_so = q[WIDTH-1]; end
         M_LSR:  begin step_q = {1'b0, q[WIDTH-1:1]};       step_so = q[0];       end
         M_ROL:  begin step_q = {q[WIDTH-2:0], q[WIDTH-1]}; step_so = q[WIDTH-1]; end
         M_ROR:  begin step_q = {q[0], q[WIDTH-1:1]};       step_so = q[0];       end
         M_ASR:  begin step_q = {q[WIDTH-1], q[WIDTH-1:1]}; step_so = q[0];       end
         M_SIL:  begin step_q = {q[WIDTH-2:0], ser_in};     step_so = q[WIDTH-1]; end
         M_SIR:  begin step_q = {ser_in, q[WIDTH-1:1]};     step_so = q[0];       end
         M_HOLD: begin step_q = q;                          step_so = 1'b0;       end
         default: begin step_q = q;                         step_so = 1'b0;       end
      endcase
   end

   always_comb begin
      state_n   = state;
      mode_n    = mode_r;
      cnt_n     = cnt;
      q_n       = q;
      busy_n    = busy;
      done_n    = 1'b0;
      ser_out_n = ser_out;
      unique case (state)
         IDLE: begin
            if (start) begin
               q_n       = in;
               mode_n    = mode_t'(mode);
               cnt_n     = amount;
               ser_out_n = 1'b0;
               if (amount != '0) begin
                  state_n = SHIFT;
                  busy_n  = 1'b1;
               end else begin
                  // Zero-length operation completes on the load edge.
                  done_n = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (abort) begin
               // No step on the abort edge; q keeps the last completed step.
               state_n = IDLE;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end else begin
               q_n       = step_q;
               ser_out_n = step_so;
               cnt_n     = cnt - AMT_W'(1);
               if (cnt == AMT_W'(1)) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         mode_r  <= M_LSL;
         cnt     <= '0;
         q       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ser_out <= 1'b0;
      end else begin
         state   <= state_n;
         mode_r  <= mode_n;
         cnt     <= cnt_n;
         q       <= q_n;
         busy    <= busy_n;
         done    <= done_n;
         ser_out <= ser_out_n;
      end
   end

endmodule

// File: tb/tb_shift_lr_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_lr_seq
//   Directed self-checking bench for shift_lr_seq (WIDTH=8, AMT_W=4).
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_shift_lr_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic [2:0] mode;
   logic [3:0] amount;
   logic [7:0] in;
   logic       ser_in;
   logic [7:0] q;
   logic       busy;
   logic       done;
   logic       ser_out;

   int n_checks;
   int n_fail;

   shift_lr_seq #(.WIDTH(8), .AMT_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .mode    (mode),
      .amount  (amount),
      .in      (in),
      .ser_in  (ser_in),
      .q       (q),
      .busy    (busy),
      .done    (done),
      .ser_out (ser_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start an operation and run to completion (bounded). Returns the final q,
   // the number of cycles busy was seen high and the OR of ser_out over steps.
   task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                         output logic [7:0] qf, output int bcyc, output logic so_or);
      mode   = m;
      amount = a;
      in     = d;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      bcyc   = 0;
      so_or  = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (busy) bcyc++;
         so_or = so_or | ser_out;
         tick();
      end
      so_or = so_or | ser_out;
      check("done_seen", {31'b0, done}, 32'd1);
      qf = q;
   endtask

   logic [7:0] exp_q  [3];
   logic       exp_so [3];
   logic [7:0] qf;
   int         bcyc;
   logic       so_or;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_q  = '{8'h6A, 8'hD4, 8'hA8};
      exp_so = '{1'b1, 1'b0, 1'b1};
      reset  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      mode   = 3'b000;
      amount = 4'd0;
      in     = 8'h00;
      ser_in = 1'b0;

      // Reset state
      repeat (2) tick();
      check("rst_q",       {24'b0, q}, 32'h0);
      check("rst_busy",    {31'b0, busy}, 32'd0);
      check("rst_done",    {31'b0, done}, 32'd0);
      check("rst_ser_out", {31'b0, ser_out}, 32'd0);
      reset = 1'b1;
      tick();

      // LSL B5 by 3, step by step
      mode = 3'b000; amount = 4'd3; in = 8'hB5; start = 1'b1;
      tick();
      start = 1'b0;
      check("lsl_load_q",    {24'b0, q}, 32'hB5);
      check("lsl_load_busy", {31'b0, busy}, 32'd1);
      check("lsl_load_so",   {31'b0, ser_out}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("lsl_q%0d", i),    {24'b0, q}, {24'b0, exp_q[i]});
         check($sformatf("lsl_so%0d", i),   {31'b0, ser_out}, {31'b0, exp_so[i]});
         check($sformatf("lsl_busy%0d", i), {31'b0, busy}, (i < 2) ? 32'd1 : 32'd0);
         check($sformatf("lsl_done%0d", i), {31'b0, done}, (i == 2) ? 32'd1 : 32'd0);
      end
      tick();
      check("lsl_done_clr", {31'b0, done}, 32'd0);

      // ROR 81 by 1 and by 9 (wraps modulo 8)
      run_op(3'b011, 4'd1, 8'h81, qf, bcyc, so_or);
      check("ror1_q", {24'b0, qf}, 32'hC0);
      check("ror1_busy_cyc", bcyc, 32'd1);
      run_op(3'b011, 4'd9, 8'h81, qf, bcyc, so_or);
      check("ror9_q", {24'b0, qf}, 32'hC0);
      check("ror9_busy_cyc", bcyc, 32'd9);

      // ROL 81 by 1
      run_op(3'b010, 4'd1, 8'h81, qf, bcyc, so_or);
      check("rol1_q", {24'b0, qf}, 32'h03);

      // ASR and saturating shifts
      run_op(3'b100, 4'd2, 8'h90, qf, bcyc, so_or);
      check("asr2_q", {24'b0, qf}, 32'hE4);
      run_op(3'b100, 4'd15, 8'h90, qf, bcyc, so_or);
      check("asr15_q", {24'b0, qf}, 32'hFF);
      check("asr15_busy_cyc", bcyc, 32'd15);
      run_op(3'b001, 4'd10, 8'hFF, qf, bcyc, so_or);
      check("lsr10_q", {24'b0, qf}, 32'h00);

      // HOLD: q unchanged, ser_out stays 0
      run_op(3'b111, 4'd2, 8'h3C, qf, bcyc, so_or);
      check("hold_q", {24'b0, qf}, 32'h3C);
      check("hold_so", {31'b0, so_or}, 32'd0);

      // SIL with ser_in=1
      ser_in = 1'b1;
      run_op(3'b101, 4'd4, 8'h00, qf, bcyc, so_or);
      check("sil_q", {24'b0, qf}, 32'h0F);
      check("sil_so", {31'b0, so_or}, 32'd0);
      ser_in = 1'b0;

      // SIR with ser_in 1,0,1
      mode = 3'b110; amount = 4'd3; in = 8'h00; start = 1'b1;
      tick();
      start = 1'b0; ser_in = 1'b1;
      tick();
      ser_in = 1'b0;
      tick();
      ser_in = 1'b1;
      tick();
      ser_in = 1'b0;
      check("sir_q",    {24'b0, q}, 32'hA0);
      check("sir_done", {31'b0, done}, 32'd1);

      // amount == 0
      tick();
      mode = 3'b000; amount = 4'd0; in = 8'h5A; start = 1'b1;
      tick();
      start = 1'b0;
      check("amt0_q",    {24'b0, q}, 32'h5A);
      check("amt0_done", {31'b0, done}, 32'd1);
      check("amt0_busy", {31'b0, busy}, 32'd0);
      tick();
      check("amt0_done_clr", {31'b0, done}, 32'd0);

      // Second start during a 5-step LSL is ignored
      mode = 3'b000; amount = 4'd5; in = 8'h01; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      mode = 3'b001; amount = 4'd1; in = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0; mode = 3'b000; amount = 4'd0; in = 8'h00;
      check("restart_busy", {31'b0, busy}, 32'd1);
      check("restart_q3",   {24'b0, q}, 32'h08);
      tick(); tick();
      check("restart_q",    {24'b0, q}, 32'h20);
      check("restart_done", {31'b0, done}, 32'd1);
      tick();

      // Abort after 2 of 5 steps
      mode = 3'b000; amount = 4'd5; in = 8'h01; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_q",    {24'b0, q}, 32'h04);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      tick(); tick();
      check("abort_q_hold",  {24'b0, q}, 32'h04);
      check("abort_no_done", {31'b0, done}, 32'd0);

      // Asynchronous reset mid-operation
      mode = 3'b010; amount = 4'd6; in = 8'hC3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      check("arst_q",    {24'b0, q}, 32'h0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_done", {31'b0, done}, 32'd0);
      tick();
      reset = 1'b1;
      tick(); tick();
      check("arst_idle_busy", {31'b0, busy}, 32'd0);
      check("arst_idle_done", {31'b0, done}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
